control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Fetch/execute control sequencer: steps through fetch (F0-F2) and execute (E3-E6)
// states, emitting registered Moore datapath strobes decoded from the latched IR fields.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | held in reset; leaves on the first Clock after Clear_n rises
// S_F0   | PC to MAR, increment PC
// S_F1   | memory read into MDR; waits here until Mem_ready
// S_F2   | MDR to IR; opcode and register fields latched on exit
// S_E3   | first execute step (operand to Y, or nop/halt/illegal completion)
// S_E4   | ALU operation into Z
// S_E5   | Z low to destination register (R-format) or to LO (mul/div)
// S_E6   | Z high to HI (mul/div only)
// S_HALT | stopped, Run low; Start resumes at F0
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear_n,
    input  logic        Start,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] R_in,
    output logic [15:0] R_out,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        Done,
    output logic        Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_HALT
    } state_t;

    typedef struct packed {
        logic        pc_out;
        logic        mar_in;
        logic        inc_pc;
        logic        z_in;
        logic        read;
        logic        mdr_in;
        logic        mdr_out;
        logic        ir_in;
        logic        y_in;
        logic        zlow_out;
        logic        zhigh_out;
        logic        hi_in;
        logic        lo_in;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [4:0]  alu_op;
        logic        run;
        logic        done;
        logic        illegal;
    } ctl_t;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, state_nxt;
    logic [4:0] op_q, op_nxt;
    logic [3:0] ra_q, ra_nxt;
    logic [3:0] rb_q, rb_nxt;
    logic [3:0] rc_q, rc_nxt;
    ctl_t       ctl_q, ctl_nxt;
    logic       is_rfmt, is_muldiv, is_nop, is_halt;
    logic       unused_ir;

    assign unused_ir = ^IR[14:0];

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            ctl_q <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
            ra_q  <= ra_nxt;
            rb_q  <= rb_nxt;
            rc_q  <= rc_nxt;
            ctl_q <= ctl_nxt;
        end
    end

    // Fields are captured leaving F2; the E3 outputs must already see the new values.
    always_comb begin
        op_nxt = op_q;
        ra_nxt = ra_q;
        rb_nxt = rb_q;
        rc_nxt = rc_q;
        if (state == S_F2) begin
            op_nxt = IR[31:27];
            ra_nxt = IR[26:23];
            rb_nxt = IR[22:19];
            rc_nxt = IR[18:15];
        end
    end

    always_comb begin
        is_rfmt   = (op_nxt >= 5'b00011) && (op_nxt <= 5'b01011);
        is_muldiv = (op_nxt == OP_MUL) || (op_nxt == OP_DIV);
        is_nop    = (op_nxt == OP_NOP);
        is_halt   = (op_nxt == OP_HALT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_F0;
            S_F0:   state_nxt = S_F1;
            S_F1:   state_nxt = Mem_ready ? S_F2 : S_F1;
            S_F2:   state_nxt = S_E3;
            S_E3: begin
                if (is_rfmt || is_muldiv) state_nxt = S_E4;
                else if (is_halt)         state_nxt = S_HALT;
                else                      state_nxt = S_F0;
            end
            S_E4:   state_nxt = S_E5;
            S_E5:   state_nxt = is_muldiv ? S_E6 : S_F0;
            S_E6:   state_nxt = S_F0;
            S_HALT: state_nxt = Start ? S_F0 : S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_comb begin
        ctl_nxt     = '0;
        ctl_nxt.run = (state_nxt != S_HALT) && (state_nxt != S_IDLE);
        case (state_nxt)
            S_F0: begin
                ctl_nxt.pc_out = 1'b1;
                ctl_nxt.mar_in = 1'b1;
                ctl_nxt.inc_pc = 1'b1;
                ctl_nxt.z_in   = 1'b1;
            end
            S_F1: begin
                ctl_nxt.read   = 1'b1;
                ctl_nxt.mdr_in = 1'b1;
            end
            S_F2: begin
                ctl_nxt.mdr_out = 1'b1;
                ctl_nxt.ir_in   = 1'b1;
            end
            S_E3: begin
                if (is_rfmt) begin
                    ctl_nxt.r_out = 16'h0001 << rb_nxt;
                    ctl_nxt.y_in  = 1'b1;
                end else if (is_muldiv) begin
                    ctl_nxt.r_out = 16'h0001 << ra_nxt;
                    ctl_nxt.y_in  = 1'b1;
                end else begin
                    ctl_nxt.done    = 1'b1;
                    ctl_nxt.illegal = !(is_nop || is_halt);
                end
            end
            S_E4: begin
                ctl_nxt.r_out  = 16'h0001 << (is_muldiv ? rb_nxt : rc_nxt);
                ctl_nxt.z_in   = 1'b1;
                ctl_nxt.alu_op = op_nxt;
            end
            S_E5: begin
                ctl_nxt.zlow_out = 1'b1;
                if (is_muldiv) begin
                    ctl_nxt.lo_in = 1'b1;
                end else begin
                    ctl_nxt.r_in = 16'h0001 << ra_nxt;
                    ctl_nxt.done = 1'b1;
                end
            end
            S_E6: begin
                ctl_nxt.zhigh_out = 1'b1;
                ctl_nxt.hi_in     = 1'b1;
                ctl_nxt.done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCout    = ctl_q.pc_out;
    assign MARin    = ctl_q.mar_in;
    assign IncPC    = ctl_q.inc_pc;
    assign Zin      = ctl_q.z_in;
    assign Read     = ctl_q.read;
    assign MDRin    = ctl_q.mdr_in;
    assign MDRout   = ctl_q.mdr_out;
    assign IRin     = ctl_q.ir_in;
    assign Yin      = ctl_q.y_in;
    assign Zlowout  = ctl_q.zlow_out;
    assign Zhighout = ctl_q.zhigh_out;
    assign HIin     = ctl_q.hi_in;
    assign LOin     = ctl_q.lo_in;
    assign R_in     = ctl_q.r_in;
    assign R_out    = ctl_q.r_out;
    assign alu_op   = ctl_q.alu_op;
    assign Run      = ctl_q.run;
    assign Done     = ctl_q.done;
    assign Illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle expected output vectors are queued as each
// instruction is driven and popped against the DUT one time unit after each rising edge.
`timescale 1ns/1ps

module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear_n;
    logic        Start;
    logic        Mem_ready;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zlowout, Zhighout, HIin, LOin;
    logic [15:0] R_in, R_out;
    logic [4:0]  alu_op;
    logic        Run, Done, Illegal;

    control_sequencer dut (
        .Clock(Clock), .Clear_n(Clear_n), .Start(Start), .Mem_ready(Mem_ready), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .R_in(R_in), .R_out(R_out), .alu_op(alu_op),
        .Run(Run), .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        pc_out, mar_in, inc_pc, z_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic        zlow_out, zhigh_out, hi_in, lo_in;
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic [4:0]  alu;
        logic        run, done, illegal;
    } ovec_t;

    localparam int S_IDLE = 0, S_F0 = 1, S_F1 = 2, S_F2 = 3, S_E3 = 4;
    localparam int S_E4 = 5, S_E5 = 6, S_E6 = 7, S_HALT = 8;

    ovec_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] ra,
                                            input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0000};
    endfunction

    function automatic ovec_t sample();
        return {PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin,
                Zlowout, Zhighout, HIin, LOin, R_in, R_out, alu_op, Run, Done, Illegal};
    endfunction

    function automatic bit op_is_r(input logic [4:0] op);
        return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                          5'b01000, 5'b01001, 5'b01010, 5'b01011};
    endfunction

    function automatic bit op_is_md(input logic [4:0] op);
        return (op == 5'b01111) || (op == 5'b10000);
    endfunction

    // Expected outputs for a given state and instruction, straight from the opcode table.
    function automatic ovec_t exp_for(input int st, input logic [31:0] ir);
        ovec_t      v;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        v = '0;
        v.run = (st != S_HALT) && (st != S_IDLE);
        case (st)
            S_F0: begin v.pc_out = 1; v.mar_in = 1; v.inc_pc = 1; v.z_in = 1; end
            S_F1: begin v.read = 1; v.mdr_in = 1; end
            S_F2: begin v.mdr_out = 1; v.ir_in = 1; end
            S_E3: begin
                if (op_is_r(op))       begin v.r_out[rb] = 1; v.y_in = 1; end
                else if (op_is_md(op)) begin v.r_out[ra] = 1; v.y_in = 1; end
                else begin
                    v.done = 1;
                    v.illegal = !(op == 5'b11010 || op == 5'b11011);
                end
            end
            S_E4: begin
                if (op_is_md(op)) v.r_out[rb] = 1;
                else              v.r_out[rc] = 1;
                v.z_in = 1;
                v.alu  = op;
            end
            S_E5: begin
                v.zlow_out = 1;
                if (op_is_md(op)) v.lo_in = 1;
                else begin v.r_in[ra] = 1; v.done = 1; end
            end
            S_E6: begin v.zhigh_out = 1; v.hi_in = 1; v.done = 1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic step(input string tag);
        ovec_t e, a;
        @(posedge Clock);
        #1;
        a = sample();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", tag, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got %h required %h", tag, $time, a, e);
            end
        end
    endtask

    // Entered just after an edge whose successor state is F0.
    task automatic run_instr(input string tag, input logic [31:0] ir, input int wait_n,
                             input logic [31:0] ir_late, input logic start_lvl);
        int n_e;
        n_e = op_is_r(ir[31:27]) ? 3 : (op_is_md(ir[31:27]) ? 4 : 1);
        IR = ir;
        Mem_ready = 1'b0;
        exp_q.push_back(exp_for(S_F0, ir)); step({tag, " F0"});
        Start = start_lvl;
        for (int i = 0; i <= wait_n; i++) begin
            exp_q.push_back(exp_for(S_F1, ir)); step({tag, " F1"});
            Mem_ready = (i == wait_n);
        end
        exp_q.push_back(exp_for(S_F2, ir)); step({tag, " F2"});
        for (int k = 0; k < n_e; k++) begin
            exp_q.push_back(exp_for(S_E3 + k, ir)); step({tag, " E"});
            if (k == 0) IR = ir_late;
        end
    endtask

    task automatic test_reset();
        Clear_n = 1'b0; Start = 1'b0; Mem_ready = 1'b0; IR = 32'hFFFF_FFFF;
        #2;
        checks++;
        if (sample() !== ovec_t'('0)) begin
            errors++; $display("FAIL reset_async: got %h required 0", sample());
        end
        exp_q.push_back(exp_for(S_IDLE, IR)); step("reset_held");
        exp_q.push_back(exp_for(S_IDLE, IR)); step("reset_held2");
        @(negedge Clock);
        Clear_n = 1'b1;
        #1;
        checks++;
        if (sample() !== ovec_t'('0)) begin
            errors++; $display("FAIL reset_idle: got %h required 0", sample());
        end
    endtask

    task automatic test_and();
        run_instr("and", 32'h2891_8000, 0, make_ir(5'b01111, 4'd9, 4'd10, 4'd11), 1'b0);
    endtask

    task automatic test_shra();
        run_instr("shra", make_ir(5'b01000, 4'd1, 4'd3, 4'd5), 0, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_muldiv();
        run_instr("mul", make_ir(5'b01111, 4'd3, 4'd4, 4'd0), 0, 32'h0000_0000, 1'b0);
        run_instr("div", make_ir(5'b10000, 4'd15, 4'd0, 4'd7), 1, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_mem_wait();
        run_instr("rol_wait", make_ir(5'b01011, 4'd14, 4'd0, 4'd15), 3, 32'h0, 1'b1);
        run_instr("nop_start", make_ir(5'b11010, 4'd2, 4'd3, 4'd4), 2, 32'h0, 1'b1);
        Start = 1'b0;
    endtask

    task automatic test_halt();
        run_instr("halt", make_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_for(S_HALT, IR)); step("halt_wait");
        end
        Start = 1'b1;
        run_instr("illegal", make_ir(5'b11111, 4'd1, 4'd2, 4'd3), 0, 32'h0, 1'b0);
        run_instr("after_ill", make_ir(5'b00011, 4'd0, 4'd8, 4'd12), 0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] ir;
        ir = make_ir(5'b01111, 4'd6, 4'd7, 4'd0);
        IR = ir; Mem_ready = 1'b1;
        for (int st = S_F0; st <= S_E4; st++) begin
            exp_q.push_back(exp_for(st, ir)); step("pre_clear");
        end
        #2;
        Clear_n = 1'b0;
        #1;
        checks++;
        if (sample() !== ovec_t'('0)) begin
            errors++; $display("FAIL clear_mid_e4: got %h required 0", sample());
        end
        @(negedge Clock);
        Clear_n = 1'b1;
        #1;
        checks++;
        if (sample() !== ovec_t'('0)) begin
            errors++; $display("FAIL clear_idle: got %h required 0", sample());
        end
        run_instr("post_clear", make_ir(5'b00100, 4'd5, 4'd6, 4'd7), 0, 32'h0, 1'b0);
        exp_q.push_back(exp_for(S_F0, IR)); step("final_f0");
    endtask

    initial begin
        test_reset();
        test_and();
        test_shra();
        test_muldiv();
        test_mem_wait();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
